// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory read/write port among requesters.
// Ports: clk/reset, per-consumer read/write req+resp, memory port, busy, grant_id, timeout_err.
module mem_rr_arbiter #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int NUM_CONSUMERS  = 4,
  parameter int WRITE_ENABLE   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CONSUMERS-1:0]         consumer_read_valid,
  input  logic [ADDR_BITS-1:0]             consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0]         consumer_read_ready,
  output logic [DATA_BITS-1:0]             consumer_read_data [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0]         consumer_write_valid,
  input  logic [ADDR_BITS-1:0]             consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]             consumer_write_data [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0]         consumer_write_ready,
  output logic                             mem_read_valid,
  output logic [ADDR_BITS-1:0]             mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [DATA_BITS-1:0]             mem_read_data,
  output logic                             mem_write_valid,
  output logic [ADDR_BITS-1:0]             mem_write_address,
  output logic [DATA_BITS-1:0]             mem_write_data,
  input  logic                             mem_write_ready,
  output logic                             busy,
  output logic [$clog2(NUM_CONSUMERS)-1:0] grant_id,
  output logic                             timeout_err
);

  localparam int GW = $clog2(NUM_CONSUMERS);
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [DATA_BITS-1:0]   rdata_q, rdata_d;
  logic [CW-1:0]          wait_cnt_q, wait_cnt_d;
  logic                   timeout_err_q, timeout_err_d;

  logic [NUM_CONSUMERS-1:0] req;
  logic [GW:0]              idx;
  logic [GW:0]              next_ptr;
  logic [CW-1:0]            wait_inc;
  logic                     win_found;
  logic [GW-1:0]            win_id;
  logic                     win_rd;

  // Writes only compete for the port when they are enabled.
  assign req = consumer_read_valid |
               ({NUM_CONSUMERS{WRITE_ENABLE != 0}} &
                consumer_write_valid);

  // Rotating scan starting at rr_ptr, wrapping N-1 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      idx = {1'b0, rr_ptr_q} + (GW+1)'(i);
      if (idx >= (GW+1)'(NUM_CONSUMERS))
        idx = idx - (GW+1)'(NUM_CONSUMERS);
      if (!win_found && req[idx[GW-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[GW-1:0];
      end
    end
  end

  // A winner holding both valids is served its read first.
  assign win_rd = consumer_read_valid[win_id];

  always_comb begin
    next_ptr = {1'b0, grant_q} + (GW+1)'(1);
    if (next_ptr == (GW+1)'(NUM_CONSUMERS))
      next_ptr = '0;
  end

  // Saturating wait counter; stays at 0 when the check is disabled.
  assign wait_inc = (wait_cnt_q == CW'(TIMEOUT_CYCLES)) ?
                    wait_cnt_q : wait_cnt_q + CW'(1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    rdata_d       = rdata_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d    = win_id;
          wait_cnt_d = '0;
          state_d    = win_rd ? READ_WAIT : WRITE_WAIT;
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          rdata_d = mem_read_data;
          state_d = READ_RELAY;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready)
          state_d = WRITE_RELAY;
        else
          wait_cnt_d = wait_inc;
      end
      READ_RELAY: begin
        if (!consumer_read_valid[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr[GW-1:0];
        end
      end
      WRITE_RELAY: begin
        if (!consumer_write_valid[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr[GW-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
    // Flag only; the pending request keeps waiting.
    if (TIMEOUT_CYCLES != 0 &&
        wait_cnt_d == CW'(TIMEOUT_CYCLES))
      timeout_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      rdata_q       <= '0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      rdata_q       <= rdata_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Moore outputs: everything not belonging to the grant is zero.
  always_comb begin
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++)
      consumer_read_data[i] = '0;
    mem_read_valid    = 1'b0;
    mem_read_address  = '0;
    mem_write_valid   = 1'b0;
    mem_write_address = '0;
    mem_write_data    = '0;
    unique case (state_q)
      READ_WAIT: begin
        mem_read_valid   = 1'b1;
        mem_read_address = consumer_read_address[grant_q];
      end
      WRITE_WAIT: begin
        if (WRITE_ENABLE != 0) begin
          mem_write_valid   = 1'b1;
          mem_write_address = consumer_write_address[grant_q];
          mem_write_data    = consumer_write_data[grant_q];
        end
      end
      READ_RELAY: begin
        consumer_read_ready[grant_q] = 1'b1;
        consumer_read_data[grant_q]  = rdata_q;
      end
      WRITE_RELAY: begin
        consumer_write_ready[grant_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_q;
  assign timeout_err = timeout_err_q;

endmodule
